// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one-at-a-time memory reads at the fetch PC and
// queues returned words in a small FIFO for the core, with redirect flush and drain.
module fetch_sequencer #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned PC_STEP = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_run,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_data,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready,
  output logic        o_busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [31:0]      STEP_C  = 32'(PC_STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [31:0]        fetch_pc_r, fetch_pc_s;
  logic [31:0]        addr_r;
  logic [CNT_W-1:0]   count_r, count_s;
  logic [PTR_W-1:0]   rd_ptr_r, wr_ptr_r;
  logic [31:0]        buf_inst_r [DEPTH];
  logic [31:0]        buf_pc_r   [DEPTH];
  logic               push_s, pop_s;

  // Buffer events, post-update count and next fetch PC; a redirect overrides everything.
  always_comb begin
    pop_s      = 1'b0;
    push_s     = 1'b0;
    count_s    = count_r;
    fetch_pc_s = fetch_pc_r;
    if (i_redirect) begin
      count_s    = '0;
      fetch_pc_s = i_redirect_pc;
    end else begin
      pop_s   = (count_r != '0) && i_inst_ready;
      push_s  = (state_r == FETCH) && i_mem_ack;
      count_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      if (push_s) begin
        fetch_pc_s = fetch_pc_r + STEP_C;
      end else begin
        fetch_pc_s = fetch_pc_r;
      end
    end
  end

  // Next-state decision; room in the buffer is judged on the post-push/post-pop count.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_run && (count_s < DEPTH_C)) state_s = FETCH;
        else                              state_s = IDLE;
      end
      FETCH: begin
        if (i_mem_ack) begin
          if (!i_run)                  state_s = IDLE;
          else if (count_s == DEPTH_C) state_s = WAIT;
          else                         state_s = FETCH;
        end else if (i_redirect) begin
          state_s = DRAIN;
        end else begin
          state_s = FETCH;
        end
      end
      WAIT: begin
        if (!i_run)                      state_s = IDLE;
        else if (count_s < DEPTH_C)      state_s = FETCH;
        else                             state_s = WAIT;
      end
      DRAIN: begin
        if (i_mem_ack) state_s = i_run ? FETCH : IDLE;
        else           state_s = DRAIN;
      end
      default: state_s = IDLE;
    endcase
  end

  // Control registers; the request address is frozen while an abandoned read drains.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= IDLE;
      fetch_pc_r <= 32'd0;
      addr_r     <= 32'd0;
      count_r    <= '0;
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
    end else begin
      state_r    <= state_s;
      fetch_pc_r <= fetch_pc_s;
      count_r    <= count_s;
      addr_r     <= (state_s == DRAIN) ? addr_r : fetch_pc_s;
      if (i_redirect) begin
        rd_ptr_r <= '0;
        wr_ptr_r <= '0;
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // Instruction storage, cleared on reset so the head outputs read zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        buf_inst_r[i] <= 32'd0;
        buf_pc_r[i]   <= 32'd0;
      end
    end else if (push_s) begin
      buf_inst_r[wr_ptr_r] <= i_mem_data;
      buf_pc_r[wr_ptr_r]   <= fetch_pc_r;
    end
  end

  assign o_mem_req    = (state_r == FETCH) || (state_r == DRAIN);
  assign o_mem_addr   = addr_r;
  assign o_inst_valid = (count_r != '0);
  assign o_inst       = buf_inst_r[rd_ptr_r];
  assign o_inst_pc    = buf_pc_r[rd_ptr_r];
  assign o_busy       = (state_r != IDLE) || (count_r != '0);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, a few hand sequences, then
// random traffic against a queue-based reference model.
module tb_fetch_sequencer;

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned PC_STEP = 1;

  logic        i_clk = 1'b0;
  logic        i_rst, i_run, i_redirect, i_mem_ack, i_inst_ready;
  logic [31:0] i_redirect_pc, i_mem_data;
  logic        o_mem_req, o_inst_valid, o_busy;
  logic [31:0] o_mem_addr, o_inst, o_inst_pc;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_sequencer #(.DEPTH(DEPTH), .PC_STEP(PC_STEP)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_run(i_run), .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
    .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data), .o_inst_valid(o_inst_valid),
    .o_inst(o_inst), .o_inst_pc(o_inst_pc), .i_inst_ready(i_inst_ready), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit rst, run, redir; logic [31:0] rpc; bit ack; logic [31:0] data; bit ready;
    bit full; bit e_req; logic [31:0] e_addr; bit e_valid;
    logic [31:0] e_pc, e_inst; bit e_busy;
  } vec_t;
  vec_t vecs[$];

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        m_q[$];
  bit          m_req, m_drop;
  logic [31:0] m_pc, m_addr;

  task automatic addv(input bit rst, run, redir, input logic [31:0] rpc, input bit ack,
                      input logic [31:0] data, input bit ready, input bit full, input bit e_req,
                      input logic [31:0] e_addr, input bit e_valid, input logic [31:0] e_pc,
                      input logic [31:0] e_inst, input bit e_busy);
    vec_t v;
    v = '{rst, run, redir, rpc, ack, data, ready, full, e_req, e_addr, e_valid, e_pc, e_inst, e_busy};
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: one outstanding read (possibly being dropped) plus a FIFO of fetched words.
  task automatic model_step(input bit rst, run, redir, input logic [31:0] rpc, input bit ack,
                            input logic [31:0] data, input bit ready);
    ent_t e;
    if (rst) begin
      m_req = 0; m_drop = 0; m_pc = 32'd0; m_addr = 32'd0; m_q.delete();
    end else begin
      if (redir) begin
        m_q.delete();
        m_pc = rpc;
        if (m_req && !ack) m_drop = 1;
        else begin m_req = 0; m_drop = 0; end
      end else begin
        if (m_q.size() != 0 && ready) void'(m_q.pop_front());
        if (m_req && ack) begin
          if (!m_drop) begin
            e.pc = m_addr; e.inst = data;
            m_q.push_back(e);
            m_pc = m_addr + PC_STEP;
          end
          m_req = 0; m_drop = 0;
        end
      end
      if (!m_req && run && m_q.size() < DEPTH) begin
        m_req = 1; m_addr = m_pc;
      end
    end
  endtask

  task automatic step(input bit rst, run, redir, input logic [31:0] rpc, input bit ack,
                      input logic [31:0] data, input bit ready);
    i_rst = rst; i_run = run; i_redirect = redir; i_redirect_pc = rpc;
    i_mem_ack = ack; i_mem_data = data; i_inst_ready = ready;
    @(posedge i_clk);
    model_step(rst, run, redir, rpc, ack, data, ready);
    #1;
  endtask

  initial begin
    bit ok;
    i_rst = 1; i_run = 0; i_redirect = 0; i_redirect_pc = 0;
    i_mem_ack = 0; i_mem_data = 0; i_inst_ready = 0;

    //   rst run rdr rpc           ack data          rdy full req addr          vld pc            inst          busy
    addv(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0,        32'h0,        0);
    addv(0, 1, 0, 32'h0,        0, 32'h0,        1, 0, 1, 32'h0,        0, 32'h0,        32'h0,        1);
    addv(0, 1, 0, 32'h0,        1, 32'hA0,       1, 0, 1, 32'h1,        1, 32'h0,        32'hA0,       1);
    addv(0, 1, 0, 32'h0,        1, 32'hA1,       1, 0, 1, 32'h2,        1, 32'h1,        32'hA1,       1);
    addv(0, 1, 0, 32'h0,        1, 32'hA2,       1, 0, 1, 32'h3,        1, 32'h2,        32'hA2,       1);
    addv(0, 1, 0, 32'h0,        1, 32'hA3,       1, 0, 1, 32'h4,        1, 32'h3,        32'hA3,       1);
    addv(0, 1, 0, 32'h0,        1, 32'hA4,       0, 0, 0, 32'h0,        1, 32'h3,        32'hA3,       1);
    addv(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h3,        32'hA3,       1);
    addv(0, 1, 0, 32'h0,        0, 32'h0,        1, 0, 1, 32'h5,        1, 32'h4,        32'hA4,       1);
    addv(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h5,        1, 32'h4,        32'hA4,       1);
    addv(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h5,        1, 32'h4,        32'hA4,       1);
    addv(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h5,        1, 32'h4,        32'hA4,       1);
    addv(0, 0, 0, 32'h0,        1, 32'hA5,       0, 0, 0, 32'h0,        1, 32'h4,        32'hA4,       1);
    addv(0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0,        1, 32'h5,        32'hA5,       1);
    addv(0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0);
    addv(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h6,        0, 32'h0,        32'h0,        1);
    addv(0, 1, 0, 32'h0,        1, 32'hA6,       0, 0, 1, 32'h7,        1, 32'h6,        32'hA6,       1);
    addv(0, 1, 1, 32'h100,      0, 32'h0,        1, 0, 1, 32'h7,        0, 32'h0,        32'h0,        1);
    addv(0, 1, 0, 32'h0,        1, 32'hDEAD,     1, 0, 1, 32'h100,      0, 32'h0,        32'h0,        1);
    addv(0, 1, 0, 32'h0,        1, 32'hB0,       0, 0, 1, 32'h101,      1, 32'h100,      32'hB0,       1);
    addv(0, 1, 1, 32'hFFFFFFFF, 1, 32'hD0,       0, 0, 1, 32'hFFFFFFFF, 0, 32'h0,        32'h0,        1);
    addv(0, 1, 0, 32'h0,        1, 32'hC0,       0, 0, 1, 32'h0,        1, 32'hFFFFFFFF, 32'hC0,       1);
    addv(0, 1, 0, 32'h0,        1, 32'hC1,       0, 0, 0, 32'h0,        1, 32'hFFFFFFFF, 32'hC0,       1);
    addv(0, 1, 0, 32'h0,        0, 32'h0,        1, 0, 1, 32'h1,        1, 32'h0,        32'hC1,       1);
    addv(1, 1, 1, 32'h55,       1, 32'hEE,       1, 1, 0, 32'h0,        0, 32'h0,        32'h0,        0);
    addv(0, 0, 0, 32'h0,        1, 32'hEE,       1, 1, 0, 32'h0,        0, 32'h0,        32'h0,        0);
    addv(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0,        0, 32'h0,        32'h0,        1);
    addv(0, 1, 1, 32'h200,      0, 32'h0,        1, 0, 1, 32'h0,        0, 32'h0,        32'h0,        1);
    addv(0, 1, 1, 32'h300,      0, 32'h0,        1, 0, 1, 32'h0,        0, 32'h0,        32'h0,        1);
    addv(0, 0, 0, 32'h0,        1, 32'hBAD,      1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0);
    addv(0, 1, 0, 32'h0,        0, 32'h0,        1, 0, 1, 32'h300,      0, 32'h0,        32'h0,        1);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].run, vecs[i].redir, vecs[i].rpc, vecs[i].ack, vecs[i].data, vecs[i].ready);
      chk($sformatf("vec%0d_req", i),   32'(o_mem_req),    32'(vecs[i].e_req));
      chk($sformatf("vec%0d_valid", i), 32'(o_inst_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_busy", i),  32'(o_busy),       32'(vecs[i].e_busy));
      if (vecs[i].e_req || vecs[i].full)
        chk($sformatf("vec%0d_addr", i), o_mem_addr, vecs[i].e_addr);
      if (vecs[i].e_valid || vecs[i].full) begin
        chk($sformatf("vec%0d_pc", i),   o_inst_pc, vecs[i].e_pc);
        chk($sformatf("vec%0d_inst", i), o_inst,    vecs[i].e_inst);
      end
    end

    // Redirect while idle, then a stalled read whose address must not move.
    step(1, 0, 0, 32'h0, 0, 32'h0, 0);
    step(0, 0, 1, 32'h40, 0, 32'h0, 0);
    chk("idle_redir_busy", 32'(o_busy), 32'd0);
    step(0, 1, 0, 32'h0, 0, 32'h0, 0);
    chk("idle_redir_req", 32'(o_mem_req), 32'd1);
    chk("idle_redir_addr", o_mem_addr, 32'h40);
    for (int k = 0; k < 3; k++) begin
      step(0, (k == 0), 0, 32'h0, 0, 32'h0, 0);
      chk($sformatf("stall%0d_addr", k), o_mem_addr, 32'h40);
      chk($sformatf("stall%0d_req", k), 32'(o_mem_req), 32'd1);
    end
    step(0, 0, 0, 32'h0, 1, 32'h1234, 0);
    ok = 0;
    for (int k = 0; k < 4 && !ok; k++) begin
      if (o_inst_valid) ok = 1;
      else step(0, 0, 0, 32'h0, 0, 32'h0, 0);
    end
    chk("late_valid_seen", 32'(ok), 32'd1);
    chk("late_valid_inst", o_inst, 32'h1234);
    chk("late_valid_pc", o_inst_pc, 32'h40);
    chk("late_req_off", 32'(o_mem_req), 32'd0);

    // Random traffic against the reference model.
    step(1, 0, 0, 32'h0, 0, 32'h0, 0);
    for (int c = 0; c < 4000; c++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFD + 32'($urandom_range(0, 2))) : $urandom;
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
           rpc, ($urandom_range(0, 2) != 0), $urandom, ($urandom_range(0, 2) != 0));
      chk("rnd_req", 32'(o_mem_req), 32'(m_req));
      chk("rnd_valid", 32'(o_inst_valid), 32'(m_q.size() != 0));
      chk("rnd_busy", 32'(o_busy), 32'(m_req || (m_q.size() != 0)));
      if (m_req) chk("rnd_addr", o_mem_addr, m_addr);
      if (m_q.size() != 0) begin
        chk("rnd_pc", o_inst_pc, m_q[0].pc);
        chk("rnd_inst", o_inst, m_q[0].inst);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 2: instruction buffer entries; power of 2, at least 2.
REQ-002 SHALL have parameter PC_STEP, default 1: PC increment per fetched instruction (word-addressed PC).
REQ-003 SHALL have port i_clk, input, 1, clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port i_run, input, 1, fetch enable.
REQ-006 SHALL have port i_redirect, input, 1, PC redirect strobe (branch/jump).
REQ-007 SHALL have port i_redirect_pc, input, 32, new fetch PC, sampled when i_redirect=1.
REQ-008 SHALL have port o_mem_req, output, 1, instruction memory read request.
REQ-009 SHALL have port o_mem_addr, output, 32, read address (fetch PC).
REQ-010 SHALL have port i_mem_ack, input, 1, read complete; i_mem_data valid this cycle.
REQ-011 SHALL have port i_mem_data, input, 32, instruction word.
REQ-012 SHALL have port o_inst_valid, output, 1, buffer head valid for the core.
REQ-013 SHALL have port o_inst, output, 32, head instruction.
REQ-014 SHALL have port o_inst_pc, output, 32, PC of head instruction.
REQ-015 SHALL have port i_inst_ready, input, 1, core accepts head.
REQ-016 SHALL have port o_busy, output, 1, high when state != IDLE or buffer non-empty.

Function
REQ-017 SHALL implement states IDLE, FETCH, WAIT, DRAIN; o_mem_req=1 only in FETCH and DRAIN.
REQ-018 SHALL hold at most one outstanding request; once raised, o_mem_req and o_mem_addr SHALL stay stable until the cycle i_mem_ack=1 (no retraction, except reset).
REQ-019 IDLE -> FETCH when i_run=1 and buffer count < DEPTH; o_mem_addr = fetch_pc.
REQ-020 FETCH with i_mem_ack=1 and no redirect: push {fetch_pc, i_mem_data}; fetch_pc += PC_STEP (mod 2^32, wraps FFFFFFFF->0); next state IDLE if i_run=0, WAIT if post-push/post-pop count == DEPTH, else FETCH (back-to-back: one instruction per cycle maximum).
REQ-021 FETCH with i_mem_ack=0: remain FETCH regardless of i_run.
REQ-022 WAIT -> FETCH when count < DEPTH and i_run=1; WAIT -> IDLE when i_run=0.
REQ-023 Buffer SHALL be FIFO; o_inst_valid = (count != 0); o_inst/o_inst_pc = head entry; pop on o_inst_valid & i_inst_ready.
REQ-024 Simultaneous push and pop SHALL keep count unchanged; push when full SHALL never occur (structurally prevented by REQ-020).
REQ-025 i_redirect=1 SHALL have priority over all other events: buffer flushed (count=0, o_inst_valid=0 next cycle, pop same cycle ignored), fetch_pc <= i_redirect_pc.
REQ-026 Redirect in FETCH with i_mem_ack=0 -> DRAIN; DRAIN keeps old request until i_mem_ack=1, discards that data, then -> FETCH (i_run=1) or IDLE.
REQ-027 Redirect in FETCH with i_mem_ack=1 same cycle: data discarded, -> FETCH at i_redirect_pc (if i_run=1, else IDLE).
REQ-028 Redirect in DRAIN: fetch_pc updated, stay DRAIN; redirect in IDLE/WAIT: flush, fetch_pc updated, state per REQ-019/022.
REQ-029 Latency: redirect at edge N -> o_mem_addr = new PC at edge N+1 (no outstanding request); ack at edge N -> o_inst_valid at N+1.

Reset
REQ-030 i_rst=1 SHALL set state IDLE, fetch_pc=0, count=0, o_mem_req=0, o_mem_addr=0, o_inst_valid=0, o_inst=0, o_inst_pc=0, o_busy=0 after the edge; outstanding request abandoned, late i_mem_ack ignored.
REQ-031 Reset SHALL take precedence over i_redirect, i_mem_ack, and pop.

Verification
REQ-032 Reset, i_run=1, ack every cycle, ready=1 -> o_inst_pc 0,1,2,3 on consecutive cycles, one instruction per cycle.
REQ-033 i_inst_ready=0, DEPTH=2 -> two pushes (PC 0,1), state WAIT, o_mem_req=0; ready=1 one cycle -> FETCH at addr 2.
REQ-034 Ack held low 3 cycles -> o_mem_addr stable at 0x5; i_run dropped meanwhile -> request completes, then IDLE.
REQ-035 Redirect to 0x100 while request to 0x7 outstanding -> buffer empty, DRAIN, 0x7 data dropped, next request addr 0x100.
REQ-036 fetch_pc=0xFFFFFFFF, ack -> o_inst_pc=0xFFFFFFFF, next o_mem_addr=0x0.
REQ-037 i_rst mid-request with 2 buffered -> next cycle all outputs 0, subsequent ack ignored.
